// File: rtl/pipe_hazard_fwd.sv
// ID/EX hazard and forwarding controller: tracks the destinations of in-flight
// instructions, registers nearest-producer selects into EX and raises load-use stalls.
module pipe_hazard_fwd #(
    parameter int AW        = 5,
    parameter int DEPTH     = 3,
    parameter int LOAD_DIST = 2,
    parameter int SW        = $clog2(DEPTH + 2)
) (
    input  logic          CLK,
    input  logic          Reset_L,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rw,
    input  logic          id_regwrite,
    input  logic          id_is_load,
    input  logic          use_shamt,
    input  logic          use_immed,
    input  logic          flush,
    input  logic          freeze,
    output logic          hazard_stall,
    output logic          ex_valid,
    output logic [SW-1:0] ex_sel_a,
    output logic [SW-1:0] ex_sel_b,
    output logic [SW-1:0] ex_sel_st
);
    localparam logic [SW-1:0] SEL_IMM = '0;
    localparam logic [SW-1:0] SEL_RF  = SW'(DEPTH + 1);
    localparam logic [SW-1:0] SEL_LD  = SW'(LOAD_DIST);

    logic [DEPTH:1]         trkV_q, trkV_d;
    logic [DEPTH:1]         trkEn_q, trkEn_d;
    logic [DEPTH:1]         trkLd_q, trkLd_d;
    logic [DEPTH:1][AW-1:0] trkRw_q, trkRw_d;

    logic          exValid_q, exValid_d;
    logic [SW-1:0] exSelA_q, exSelA_d;
    logic [SW-1:0] exSelB_q, exSelB_d;
    logic [SW-1:0] exSelSt_q, exSelSt_d;

    logic [SW-1:0] selRs, selRt, selA, selB;
    logic          ldRs, ldRt, hazRs, hazRt, hazard, bubble;

    // Scan from the far end so the nearest matching producer overwrites the result.
    always_comb begin
        selRs = SEL_RF;
        selRt = SEL_RF;
        ldRs  = 1'b0;
        ldRt  = 1'b0;
        for (int d = DEPTH; d >= 1; d--) begin
            if (trkV_q[d] && trkEn_q[d] && (trkRw_q[d] == id_rs) && (id_rs != '0)) begin
                selRs = SW'(d);
                ldRs  = trkLd_q[d];
            end
            if (trkV_q[d] && trkEn_q[d] && (trkRw_q[d] == id_rt) && (id_rt != '0)) begin
                selRt = SW'(d);
                ldRt  = trkLd_q[d];
            end
        end
    end

    assign selA   = use_shamt ? SEL_IMM : selRs;
    assign selB   = use_immed ? SEL_IMM : selRt;
    assign hazRs  = !use_shamt && ldRs && (selRs < SEL_LD);
    assign hazRt  = ldRt && (selRt < SEL_LD);
    assign hazard = id_valid && (hazRs || hazRt);

    assign hazard_stall = hazard && !flush && !freeze;
    assign bubble       = flush || hazard_stall;

    always_comb begin
        trkV_d    = trkV_q;
        trkEn_d   = trkEn_q;
        trkLd_d   = trkLd_q;
        trkRw_d   = trkRw_q;
        exValid_d = exValid_q;
        exSelA_d  = exSelA_q;
        exSelB_d  = exSelB_q;
        exSelSt_d = exSelSt_q;
        if (!freeze) begin
            for (int d = DEPTH; d >= 2; d--) begin
                trkV_d[d]  = trkV_q[d-1];
                trkEn_d[d] = trkEn_q[d-1];
                trkLd_d[d] = trkLd_q[d-1];
                trkRw_d[d] = trkRw_q[d-1];
            end
            if (bubble) begin
                trkV_d[1]  = 1'b0;
                trkEn_d[1] = 1'b0;
                trkLd_d[1] = 1'b0;
                trkRw_d[1] = '0;
                exValid_d  = 1'b0;
                exSelA_d   = SEL_RF;
                exSelB_d   = SEL_RF;
                exSelSt_d  = SEL_RF;
            end else begin
                trkV_d[1]  = id_valid;
                trkEn_d[1] = id_regwrite;
                trkLd_d[1] = id_is_load;
                trkRw_d[1] = id_rw;
                exValid_d  = id_valid;
                exSelA_d   = selA;
                exSelB_d   = selB;
                exSelSt_d  = selRt;
            end
        end
    end

    // Reset wins over freeze so a held pipeline can still be cleared.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            trkV_q    <= '0;
            trkEn_q   <= '0;
            trkLd_q   <= '0;
            trkRw_q   <= '0;
            exValid_q <= 1'b0;
            exSelA_q  <= SEL_RF;
            exSelB_q  <= SEL_RF;
            exSelSt_q <= SEL_RF;
        end else begin
            trkV_q    <= trkV_d;
            trkEn_q   <= trkEn_d;
            trkLd_q   <= trkLd_d;
            trkRw_q   <= trkRw_d;
            exValid_q <= exValid_d;
            exSelA_q  <= exSelA_d;
            exSelB_q  <= exSelB_d;
            exSelSt_q <= exSelSt_d;
        end
    end

    assign ex_valid  = exValid_q;
    assign ex_sel_a  = exSelA_q;
    assign ex_sel_b  = exSelB_q;
    assign ex_sel_st = exSelSt_q;

endmodule
